mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the CPU's data/instruction memory port. Replaces the
//   fixed-timing memory with a req/ack handshake: the control unit issues a request
//   and stalls until resp_valid. Word-addressed storage, configurable wait states,
//   and an error flag for misaligned or out-of-range accesses.
// PARAMETERS
//   DEPTH_WORDS  64  number of 32-bit words stored (byte space = 4*DEPTH_WORDS)
//   WAIT_CYCLES  1   extra cycles between accept and response (0..15)
// PORTS
//   clock       in   1   system clock, all state on rising edge
//   reset       in   1   synchronous, active-high
//   req_valid   in   1   request present this cycle
//   req_write   in   1   1 = write, 0 = read
//   req_addr    in   32  byte address; must be word-aligned
//   req_wdata   in   32  write data
//   req_ready   out  1   responder can accept a request this cycle
//   resp_valid  out  1   one-cycle pulse: access complete
//   resp_rdata  out  32  read data; valid only while resp_valid, else 0
//   resp_err    out  1   access rejected; valid only while resp_valid, else 0
//   busy        out  1   request in flight (state != IDLE)
// BEHAVIOUR
//   Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
//     Storage contents are NOT cleared by reset.
//   States: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On req_valid=1 -> accept: latch write/addr/wdata, load
//     counter with WAIT_CYCLES; next = WAIT if WAIT_CYCLES>0, else RESP.
//   WAIT: req_ready=0; counter decrements each cycle; at counter==1 next = RESP.
//   RESP: resp_valid=1 for exactly one cycle, req_ready=0; next = IDLE.
//   Latency: request accepted in cycle N -> resp_valid in cycle N+1+WAIT_CYCLES.
//     No back-to-back accept: next accept earliest in cycle N+2+WAIT_CYCLES.
//   Access commits on the edge entering RESP: write updates mem[addr[31:2]];
//     read data is registered then and presented in RESP.
//   Error: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> resp_err=1, resp_rdata=0,
//     storage unchanged (write suppressed).
//   Inputs are ignored outside IDLE; req_addr/req_wdata may change after accept.
//   Reset mid-operation (WAIT or RESP entry pending): request aborted, no
//     resp_valid, pending write discarded; state returns to IDLE next cycle.
//   Reset during the commit edge wins: write does not occur.
// TESTING
//   1. WAIT=1: write 0xDEADBEEF @0x10 accepted cycle N -> resp_valid at N+2,
//      err=0; then read @0x10 -> resp_rdata=0xDEADBEEF with resp_valid.
//   2. Write 0x11111111 @0x12 (misaligned) -> resp_err=1, rdata=0; read @0x10
//      still returns 0xDEADBEEF.
//   3. DEPTH=64: read @0x100 -> resp_err=1, resp_rdata=0; write @0xFC ok, err=0.
//   4. Mem[0x20]=0x5; write 0x1234 @0x20, assert reset during WAIT -> no
//      resp_valid, busy=0 next cycle; read @0x20 -> 0x5.
//   5. req_valid held high with 4 queued reads, WAIT=2 -> accepts spaced every
//      4 cycles, req_ready=0 throughout WAIT/RESP, exactly 4 resp_valid pulses.
//   6. WAIT_CYCLES=0 build: read accepted cycle N -> resp_valid at N+1.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the CPU control unit and mem_responder
interface mem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory behind a req/ack handshake with configurable wait states
module mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clock,
   input  logic            reset,
   mem_responder_if.slave  bus,
   output logic            busy
);
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic        acc_write;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [AW-1:0] acc_idx;
   logic        acc_bad;
   logic        commit;
   logic        mem_we;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // With zero wait states the access commits on the accept edge, so it must use the live request.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_write = bus.req_write;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
      end else begin
         acc_write = wr_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
      acc_idx = acc_addr[AW+1:2];
      acc_bad = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      commit  = (state_d == S_RESP) && (state_q != S_RESP);
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d   = acc_bad;
         rdata_d = (acc_bad || acc_write) ? 32'h0 : mem_q[acc_idx];
      end
      mem_we = commit && acc_write && !acc_bad && !reset;
   end

   // Storage has no reset: contents survive a reset by design.
   always_ff @(posedge clock) begin
      if (mem_we) mem_q[acc_idx] <= acc_wdata;
   end

   always_comb begin
      bus.req_ready  = (state_q == S_IDLE);
      bus.resp_valid = (state_q == S_RESP);
      bus.resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
      bus.resp_err   = (state_q == S_RESP) ? err_q : 1'b0;
      busy           = (state_q != S_IDLE);
   end
endmodule
